// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame controller with mid-bit majority sampling, parity and stop checks
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [3:0]            edge_count,
  input  logic [4:0]            bit_count,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  cnt_enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [4:0] LAST_BIT = 5'(DATA_WIDTH);
  state_t state;
  logic [2:0] samples;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic par_en, par_typ, sampled_bit, mid, last;
  assign sampled_bit = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
  assign mid = edge_count == 4'd6;
  assign last = edge_count == 4'd7;
  always_ff @(posedge clk_based_on_prescale)
    samples <= !RST ? '0 : {edge_count == 4'd5 ? RX_IN : samples[2],
                            edge_count == 4'd4 ? RX_IN : samples[1],
                            edge_count == 4'd3 ? RX_IN : samples[0]};
  always_ff @(posedge clk_based_on_prescale) begin
    if (!RST) begin
      state <= IDLE;
      cnt_enable <= 1'b0;
      P_DATA <= '0;
      data_valid <= 1'b0;
      parity_error <= 1'b0;
      stop_error <= 1'b0;
      shift_reg <= '0;
      par_en <= 1'b0;
      par_typ <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE:
          if (!RX_IN) begin
            state <= START;
            cnt_enable <= 1'b1;
            par_en <= PAR_EN;
            par_typ <= PAR_TYP;
            parity_error <= 1'b0;
            stop_error <= 1'b0;
          end
        START:
          if (mid && sampled_bit) begin
            state <= IDLE;
            cnt_enable <= 1'b0;
          end else if (last && bit_count == 5'd0) state <= DATA;
        DATA: begin
          if (mid) shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
          if (last && bit_count == LAST_BIT) state <= par_en ? PARITY : STOP;
        end
        PARITY: begin
          if (mid && sampled_bit != (^shift_reg ^ par_typ)) parity_error <= 1'b1;
          if (last) state <= STOP;
        end
        STOP: begin
          if (mid && !sampled_bit) stop_error <= 1'b1;
          if (last) begin
            state <= IDLE;
            cnt_enable <= 1'b0;
            // flags from earlier edges of this frame are already settled here
            if (!parity_error && !stop_error) begin
              P_DATA <= shift_reg;
              data_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frame vectors against uart_rx_fsm with a behavioural edge/bit counter
module tb_uart_rx_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic [3:0] ec = '0;
  logic [4:0] bc = '0;
  logic par_en = 1'b0;
  logic par_typ = 1'b0;
  logic cnt_enable, data_valid, parity_error, stop_error;
  logic [7:0] p_data;
  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  int dv_cnt = 0;

  typedef struct {
    logic [7:0] data;
    bit pe, pt, pb, sb, noise, chg, exp_dv;
    logic [7:0] exp_pdata;
    bit exp_perr, exp_serr;
    int exp_en;
  } vec_t;
  vec_t vecs[8];

  uart_rx_fsm #(.DATA_WIDTH(8)) dut (
    .clk_based_on_prescale(clk),
    .RST(rst_n),
    .RX_IN(rx),
    .edge_count(ec),
    .bit_count(bc),
    .PAR_EN(par_en),
    .PAR_TYP(par_typ),
    .cnt_enable(cnt_enable),
    .P_DATA(p_data),
    .data_valid(data_valid),
    .parity_error(parity_error),
    .stop_error(stop_error)
  );

  always #5 clk = ~clk;

  // upstream counter: held at zero while disabled, 8 edges per bit
  always @(posedge clk) begin
    if (!cnt_enable) begin
      ec <= '0;
      bc <= '0;
    end else if (ec == 4'd7) begin
      ec <= '0;
      bc <= bc + 5'd1;
    end else ec <= ec + 4'd1;
  end

  always @(negedge clk) begin
    if (cnt_enable) en_cnt++;
    if (data_valid) dv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit flip, input int pos);
    for (int j = 0; j < 8; j++) begin
      rx = (flip && j == pos) ? ~b : b;
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt, input bit pb,
                            input bit sb, input bit noise, input bit chg, input int gap);
    par_en = pe;
    par_typ = pt;
    send_bit(1'b0, 1'b0, 0);
    if (chg) begin
      par_en = !pe;
      par_typ = !pt;
    end
    for (int i = 0; i < 8; i++) send_bit(d[i], noise, 4 + i % 3);
    if (pe) send_bit(pb, 1'b0, 0);
    send_bit(sb, 1'b0, 0);
    rx = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic check_outputs(input string tag, input int dv, input int pd, input int pe, input int se, input int en);
    check({tag, " data_valid pulses"}, dv_cnt, dv);
    check({tag, " P_DATA"}, p_data, pd);
    check({tag, " parity_error"}, parity_error, pe);
    check({tag, " stop_error"}, stop_error, se);
    check({tag, " enabled cycles"}, en_cnt, en);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 0, 0, 0, 1, 0, 0, 1, 8'hA5, 0, 0, 80};
    vecs[1] = '{8'h3C, 1, 0, 0, 1, 0, 0, 1, 8'h3C, 0, 0, 88};
    vecs[2] = '{8'h3C, 1, 0, 1, 1, 0, 0, 0, 8'h3C, 1, 0, 88};
    vecs[3] = '{8'hFF, 0, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 1, 80};
    vecs[4] = '{8'h12, 0, 0, 0, 1, 0, 0, 1, 8'h12, 0, 0, 80};
    vecs[5] = '{8'h5A, 0, 0, 0, 1, 1, 0, 1, 8'h5A, 0, 0, 80};
    vecs[6] = '{8'h96, 1, 1, 1, 1, 0, 0, 1, 8'h96, 0, 0, 88};
    vecs[7] = '{8'h0F, 1, 0, 0, 1, 0, 1, 1, 8'h0F, 0, 0, 88};

    repeat (3) tick();
    check("reset cnt_enable", cnt_enable, 0);
    check("reset data_valid", data_valid, 0);
    check("reset P_DATA", p_data, 0);
    check("reset parity_error", parity_error, 0);
    check("reset stop_error", stop_error, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    for (int v = 0; v < 8; v++) begin
      en_cnt = 0;
      dv_cnt = 0;
      send_frame(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].pb, vecs[v].sb, vecs[v].noise, vecs[v].chg, 4);
      check_outputs($sformatf("vec%0d", v), vecs[v].exp_dv, vecs[v].exp_pdata,
                    vecs[v].exp_perr, vecs[v].exp_serr, vecs[v].exp_en);
    end

    en_cnt = 0;
    dv_cnt = 0;
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    repeat (12) tick();
    check_outputs("glitch", 0, 8'h0F, 0, 0, 7);
    check("glitch cnt_enable", cnt_enable, 0);

    en_cnt = 0;
    dv_cnt = 0;
    send_frame(8'h33, 0, 0, 0, 1, 0, 0, 0);
    send_frame(8'hC4, 0, 0, 0, 1, 0, 0, 4);
    check_outputs("back2back", 2, 8'hC4, 0, 0, 160);

    par_en = 1'b0;
    send_bit(1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(i != 2, 1'b0, 0);
    repeat (3) tick();
    rx = 1'b1;
    rst_n = 1'b0;
    tick();
    check("midreset cnt_enable", cnt_enable, 0);
    check("midreset data_valid", data_valid, 0);
    check("midreset P_DATA", p_data, 0);
    check("midreset parity_error", parity_error, 0);
    check("midreset stop_error", stop_error, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    check("after reset idle", cnt_enable, 0);
    en_cnt = 0;
    dv_cnt = 0;
    send_frame(8'h81, 0, 0, 0, 1, 0, 0, 4);
    check_outputs("post reset", 1, 8'h81, 0, 0, 80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
